bus_access_ctrl: RTL and testbench



---
 rtl/bus_access_ctrl_pkg.sv | 26 ++
 rtl/bus_access_ctrl_rr_arbiter2.sv | 50 +++++
 rtl/bus_access_ctrl.sv | 158 +++++++++++++++
 tb/tb_bus_access_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_access_ctrl_pkg.sv
// Shared definitions for the bus access controller.
// Holds the FSM state encoding, the default I/O base address, and the
// grant / last-grant encodings used between the top and the arbiter.
package bus_access_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDmem,
    StDioWait,
    StDioDone
  } state_e;

  // Lowest data address that decodes as I/O space (I/O is IoBaseDefault..255).
  localparam logic [7:0] IoBaseDefault = 8'd248;

  // One-hot grant vector: bit 0 = fetch, bit 1 = data.
  localparam logic [1:0] GrantNone  = 2'b00;
  localparam logic [1:0] GrantFetch = 2'b01;
  localparam logic [1:0] GrantData  = 2'b10;

  // Encoding of the arbiter's last-grant memory.
  localparam logic LastFetch = 1'b0;
  localparam logic LastData  = 1'b1;

endpackage

// File: rtl/bus_access_ctrl_rr_arbiter2.sv
// Two-input round-robin arbiter.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   req_i[1:0] - requests (bit 0 = fetch, bit 1 = data)
//   enable_i   - arbitration allowed this cycle (controller is idle)
//   grant_o    - one-hot grant, all zero when disabled or nothing requested
// The last winner is remembered so that a tie goes to the other requester.
// Reset leaves last grant at data, so fetch wins the first tie.
module bus_access_ctrl_rr_arbiter2
  import bus_access_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       enable_i,
  output logic [1:0] grant_o
);

  logic last_q, last_d;

  always_comb begin
    grant_o = GrantNone;
    if (enable_i) begin
      unique case (req_i)
        2'b01:   grant_o = GrantFetch;
        2'b10:   grant_o = GrantData;
        2'b11:   grant_o = (last_q == LastData) ? GrantFetch : GrantData;
        default: grant_o = GrantNone;
      endcase
    end
  end

  always_comb begin
    last_d = last_q;
    if (grant_o == GrantFetch) begin
      last_d = LastFetch;
    end else if (grant_o == GrantData) begin
      last_d = LastData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= LastData;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/bus_access_ctrl.sv
// Sequencer and arbiter for the shared 8-bit memory / I-O address path.
// Grants fetch or data access to the address decoder, latches the address,
// inserts IO_WAIT wait states for I/O-space data accesses and returns a
// one-cycle acknowledge to the requester whose access completes.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   if_req_i, if_addr_i        - fetch request / address; if_ack_o pulse on completion
//   d_req_i, d_we_i, d_addr_i  - data request / write flag / address; d_ack_o pulse
//   sel_o                      - decoder select: 0 = ia_out_o, 1 = da_out_o
//   ia_out_o, da_out_o         - latched fetch / data addresses
//   mem_we_o, io_re_o, io_we_o - memory write, I/O read, I/O write strobes
//   busy_o                     - high whenever an access is in progress
module bus_access_ctrl
  import bus_access_ctrl_pkg::*;
#(
  parameter int unsigned IO_WAIT = 2,
  parameter logic [7:0]  IO_BASE = IoBaseDefault
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       if_req_i,
  input  logic [7:0] if_addr_i,
  output logic       if_ack_o,
  input  logic       d_req_i,
  input  logic       d_we_i,
  input  logic [7:0] d_addr_i,
  output logic       d_ack_o,
  output logic       sel_o,
  output logic [7:0] ia_out_o,
  output logic [7:0] da_out_o,
  output logic       mem_we_o,
  output logic       io_re_o,
  output logic       io_we_o,
  output logic       busy_o
);

  // Wait counter is 4 bits; IO_WAIT is expected in 0..15.
  localparam logic [3:0] IoWaitCnt = 4'(IO_WAIT);

  state_e     state_q, state_d;
  logic [7:0] ia_q, ia_d;
  logic [7:0] da_q, da_d;
  logic       we_q, we_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] grant;
  logic       arb_en;

  // Requests are only considered while idle.
  assign arb_en = (state_q == StIdle);

  bus_access_ctrl_rr_arbiter2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    ({d_req_i, if_req_i}),
    .enable_i (arb_en),
    .grant_o  (grant)
  );

  // State and latched-operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ia_q    <= 8'd0;
      da_q    <= 8'd0;
      we_q    <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      ia_q    <= ia_d;
      da_q    <= da_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    ia_d    = ia_q;
    da_d    = da_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (grant == GrantFetch) begin
          state_d = StFetch;
          ia_d    = if_addr_i;
        end else if (grant == GrantData) begin
          da_d = d_addr_i;
          we_d = d_we_i;
          if (d_addr_i < IO_BASE) begin
            state_d = StDmem;
          end else if (IoWaitCnt == 4'd0) begin
            state_d = StDioDone;
          end else begin
            state_d = StDioWait;
            cnt_d   = IoWaitCnt;
          end
        end
      end
      StDioWait: begin
        // Counter runs IO_WAIT down to 1; the cycle showing 1 is the last wait.
        if (cnt_q <= 4'd1) begin
          state_d = StDioDone;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StFetch, StDmem, StDioDone: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Outputs decoded purely from state so reset clears them immediately.
  always_comb begin
    if_ack_o = 1'b0;
    d_ack_o  = 1'b0;
    sel_o    = 1'b0;
    mem_we_o = 1'b0;
    io_re_o  = 1'b0;
    io_we_o  = 1'b0;
    unique case (state_q)
      StFetch: begin
        if_ack_o = 1'b1;
      end
      StDmem: begin
        sel_o    = 1'b1;
        d_ack_o  = 1'b1;
        mem_we_o = we_q;
      end
      StDioWait: begin
        sel_o   = 1'b1;
        io_re_o = ~we_q;
      end
      StDioDone: begin
        sel_o   = 1'b1;
        d_ack_o = 1'b1;
        io_we_o = we_q;
        io_re_o = ~we_q;
      end
      default: begin
        sel_o = 1'b0;
      end
    endcase
  end

  assign busy_o   = (state_q != StIdle);
  assign ia_out_o = ia_q;
  assign da_out_o = da_q;

endmodule

// File: tb/tb_bus_access_ctrl.sv
// Directed bench for bus_access_ctrl. Two instances: IO_WAIT=2 and IO_WAIT=0.
// Output flags are packed as {busy, sel, if_ack, d_ack, mem_we, io_re, io_we}.
module tb_bus_access_ctrl;

  logic       clk;
  logic       rst_n;
  logic       if_req, d_req, d_we;
  logic [7:0] if_addr, d_addr;
  logic       if_ack, d_ack, sel, mem_we, io_re, io_we, busy;
  logic [7:0] ia_out, da_out;

  logic       d0_req, d0_we;
  logic [7:0] d0_addr;
  logic       if0_ack, d0_ack, sel0, mem_we0, io_re0, io_we0, busy0;
  logic [7:0] ia_out0, da_out0;

  logic [6:0] flg, flg0;

  int unsigned n_cmp;
  int unsigned n_bad;

  localparam logic [6:0] FIdle   = 7'b0000000;
  localparam logic [6:0] FFetch  = 7'b1010000;
  localparam logic [6:0] FDmemR  = 7'b1101000;
  localparam logic [6:0] FDmemW  = 7'b1101100;
  localparam logic [6:0] FWaitR  = 7'b1100010;
  localparam logic [6:0] FWaitW  = 7'b1100000;
  localparam logic [6:0] FDoneR  = 7'b1101010;
  localparam logic [6:0] FDoneW  = 7'b1101001;

  bus_access_ctrl #(.IO_WAIT(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req_i  (if_req),
    .if_addr_i (if_addr),
    .if_ack_o  (if_ack),
    .d_req_i   (d_req),
    .d_we_i    (d_we),
    .d_addr_i  (d_addr),
    .d_ack_o   (d_ack),
    .sel_o     (sel),
    .ia_out_o  (ia_out),
    .da_out_o  (da_out),
    .mem_we_o  (mem_we),
    .io_re_o   (io_re),
    .io_we_o   (io_we),
    .busy_o    (busy)
  );

  bus_access_ctrl #(.IO_WAIT(0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req_i  (1'b0),
    .if_addr_i (8'd0),
    .if_ack_o  (if0_ack),
    .d_req_i   (d0_req),
    .d_we_i    (d0_we),
    .d_addr_i  (d0_addr),
    .d_ack_o   (d0_ack),
    .sel_o     (sel0),
    .ia_out_o  (ia_out0),
    .da_out_o  (da_out0),
    .mem_we_o  (mem_we0),
    .io_re_o   (io_re0),
    .io_we_o   (io_we0),
    .busy_o    (busy0)
  );

  assign flg  = {busy, sel, if_ack, d_ack, mem_we, io_re, io_we};
  assign flg0 = {busy0, sel0, if0_ack, d0_ack, mem_we0, io_re0, io_we0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    if_req  = 1'b0;
    if_addr = 8'h00;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = 8'h00;
    d0_req  = 1'b0;
    d0_we   = 1'b0;
    d0_addr = 8'h00;

    #3;
    check_eq("reset_flags", 32'(flg), 32'(FIdle));
    check_eq("reset_ia", 32'(ia_out), 32'h00);
    check_eq("reset_da", 32'(da_out), 32'h00);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 1: lone fetch
    if_req  = 1'b1;
    if_addr = 8'h3C;
    tick();
    check_eq("t1_fetch_flags", 32'(flg), 32'(FFetch));
    check_eq("t1_ia_out", 32'(ia_out), 32'h3C);
    if_req  = 1'b0;
    if_addr = 8'h77;
    tick();
    check_eq("t1_idle_flags", 32'(flg), 32'(FIdle));
    check_eq("t1_ia_hold", 32'(ia_out), 32'h3C);
    tick();
    check_eq("t1_one_pulse", 32'(flg), 32'(FIdle));

    // 2: memory write
    d_req  = 1'b1;
    d_we   = 1'b1;
    d_addr = 8'd100;
    tick();
    check_eq("t2_dmem_flags", 32'(flg), 32'(FDmemW));
    check_eq("t2_da_out", 32'(da_out), 32'd100);
    d_req = 1'b0;
    tick();
    check_eq("t2_idle_flags", 32'(flg), 32'(FIdle));

    // 3: I/O read with two wait states, address changed mid-access
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 8'd250;
    tick();
    check_eq("t3r_wait1", 32'(flg), 32'(FWaitR));
    d_addr = 8'd5;
    d_we   = 1'b1;
    tick();
    check_eq("t3r_wait2", 32'(flg), 32'(FWaitR));
    tick();
    check_eq("t3r_done", 32'(flg), 32'(FDoneR));
    check_eq("t3r_da_held", 32'(da_out), 32'd250);
    d_req = 1'b0;
    tick();
    check_eq("t3r_idle", 32'(flg), 32'(FIdle));

    // 3b: I/O write, io_we only in the done cycle
    d_req  = 1'b1;
    d_we   = 1'b1;
    d_addr = 8'd255;
    tick();
    check_eq("t3w_wait1", 32'(flg), 32'(FWaitW));
    tick();
    check_eq("t3w_wait2", 32'(flg), 32'(FWaitW));
    tick();
    check_eq("t3w_done", 32'(flg), 32'(FDoneW));
    d_req = 1'b0;
    tick();
    check_eq("t3w_idle", 32'(flg), 32'(FIdle));

    // 4: round robin from fresh reset, both held high
    rst_n = 1'b0;
    #1;
    check_eq("t4_reset_ia", 32'(ia_out), 32'h00);
    rst_n = 1'b1;
    tick();
    if_req  = 1'b1;
    if_addr = 8'h11;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 8'h20;
    tick();
    check_eq("t4_g1_fetch", 32'(flg), 32'(FFetch));
    tick();
    check_eq("t4_gap1", 32'(flg), 32'(FIdle));
    tick();
    check_eq("t4_g2_data", 32'(flg), 32'(FDmemR));
    check_eq("t4_da", 32'(da_out), 32'h20);
    tick();
    check_eq("t4_gap2", 32'(flg), 32'(FIdle));
    tick();
    check_eq("t4_g3_fetch", 32'(flg), 32'(FFetch));
    tick();
    check_eq("t4_gap3", 32'(flg), 32'(FIdle));
    tick();
    check_eq("t4_g4_data", 32'(flg), 32'(FDmemR));
    if_req = 1'b0;
    d_req  = 1'b0;
    tick();
    check_eq("t4_end_idle", 32'(flg), 32'(FIdle));

    // 5: boundaries
    d_req  = 1'b1;
    d_we   = 1'b1;
    d_addr = 8'd247;
    tick();
    check_eq("t5_247_mem", 32'(flg), 32'(FDmemW));
    d_req = 1'b0;
    tick();
    check_eq("t5_247_idle", 32'(flg), 32'(FIdle));
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 8'd248;
    tick();
    check_eq("t5_248_wait1", 32'(flg), 32'(FWaitR));
    tick();
    check_eq("t5_248_wait2", 32'(flg), 32'(FWaitR));
    tick();
    check_eq("t5_248_done", 32'(flg), 32'(FDoneR));
    d_req = 1'b0;
    tick();
    check_eq("t5_248_idle", 32'(flg), 32'(FIdle));
    d0_req  = 1'b1;
    d0_we   = 1'b0;
    d0_addr = 8'd248;
    tick();
    check_eq("t5_w0_done", 32'(flg0), 32'(FDoneR));
    check_eq("t5_w0_da", 32'(da_out0), 32'd248);
    d0_req = 1'b0;
    tick();
    check_eq("t5_w0_idle", 32'(flg0), 32'(FIdle));

    // 6: reset during wait, request held, access restarts
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 8'd252;
    tick();
    check_eq("t6_wait", 32'(flg), 32'(FWaitR));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_async_clear", 32'(flg), 32'(FIdle));
    check_eq("t6_da_clear", 32'(da_out), 32'h00);
    #2;
    rst_n = 1'b1;
    tick();
    check_eq("t6_restart_wait1", 32'(flg), 32'(FWaitR));
    check_eq("t6_restart_da", 32'(da_out), 32'd252);
    tick();
    check_eq("t6_restart_wait2", 32'(flg), 32'(FWaitR));
    tick();
    check_eq("t6_restart_done", 32'(flg), 32'(FDoneR));
    d_req = 1'b0;
    tick();
    check_eq("t6_idle", 32'(flg), 32'(FIdle));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
